// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the CPU bus, extracts and extends load data, and holds the MEM/WB register.
// SB/SH use a two-cycle read-modify-write. Build option MEM_MISALIGN_EXC_EN flags misaligned accesses.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_en,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [31:0] ex_out,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    output logic [29:0] addr,
    output logic        as_,
    output logic        rw,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    output logic        mem_busy,
    output logic        mem_en,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [31:0] mem_out,
    output logic        mem_misalign,
    output logic        state_dbg
);
    typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

    localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
                           OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;

    // Bus handshake: as_ low for exactly one cycle per access; rw=1 READ, rw=0 WRITE.
    // rd_data is valid in the same cycle as the strobe; writes commit on the rising edge.

    state_t      state;
    logic [31:0] merge_q;
    logic        is_load, is_store, is_sub, mis, req;
    logic [31:0] load_data, merged;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign addr      = ex_out[31:2];
    assign state_dbg = state;

    always_comb begin
        is_load  = (ex_mem_op >= OP_LW) && (ex_mem_op <= OP_LBU);
        is_store = (ex_mem_op >= OP_SW) && (ex_mem_op <= OP_SB);
        is_sub   = (ex_mem_op == OP_SH) || (ex_mem_op == OP_SB);
`ifdef MEM_MISALIGN_EXC_EN
        mis = (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW)) && (ex_out[1:0] != 2'b00)) ||
              (((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH)) && ex_out[0]);
`else
        mis = 1'b0;
`endif
        req = ex_en && (is_load || is_store) && !mis && !flush && !reset;
    end

    // Lane extraction and merge; without the misalign option low address bits are simply ignored.
    always_comb begin
        lane_h = ex_out[1] ? rd_data[31:16] : rd_data[15:0];
        case (ex_out[1:0])
            2'd0:    lane_b = rd_data[7:0];
            2'd1:    lane_b = rd_data[15:8];
            2'd2:    lane_b = rd_data[23:16];
            default: lane_b = rd_data[31:24];
        endcase
        case (ex_mem_op)
            OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  load_data = {16'h0000, lane_h};
            OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  load_data = {24'h000000, lane_b};
            default: load_data = rd_data;
        endcase
        merged = rd_data;
        if (ex_mem_op == OP_SH) begin
            if (ex_out[1]) merged[31:16] = ex_mem_wr_data[15:0];
            else           merged[15:0]  = ex_mem_wr_data[15:0];
        end else begin
            case (ex_out[1:0])
                2'd0:    merged[7:0]   = ex_mem_wr_data[7:0];
                2'd1:    merged[15:8]  = ex_mem_wr_data[7:0];
                2'd2:    merged[23:16] = ex_mem_wr_data[7:0];
                default: merged[31:24] = ex_mem_wr_data[7:0];
            endcase
        end
    end

    assign mem_busy = (state == IDLE) && req && is_sub && !stall;

    always_comb begin
        as_     = 1'b1;
        rw      = 1'b1;
        wr_data = ex_mem_wr_data;
        if (state == RMW_WR) begin
            if (!stall && !flush && !reset) begin
                as_     = 1'b0;
                rw      = 1'b0;
                wr_data = merge_q;
            end
        end else if (req) begin
            if (is_sub) begin
                as_ = stall;
            end else begin
                as_ = 1'b0;
                rw  = (ex_mem_op != OP_SW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            merge_q <= 32'h0;
        end else begin
            case (state)
                IDLE: if (mem_busy) begin
                    state   <= RMW_WR;
                    merge_q <= merged;
                end
                RMW_WR: if (flush || !stall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            mem_en       <= 1'b0;
            mem_dst_addr <= 5'd0;
            mem_gpr_we_  <= 1'b1;
            mem_out      <= 32'h0;
            mem_misalign <= 1'b0;
        end else if (stall) begin
            mem_en <= mem_en;
        end else if (mem_busy) begin
            mem_en       <= 1'b0;
            mem_gpr_we_  <= 1'b1;
            mem_misalign <= 1'b0;
        end else begin
            mem_en       <= ex_en;
            mem_dst_addr <= ex_dst_addr;
            mem_gpr_we_  <= ex_gpr_we_ || is_store || mis;
            mem_out      <= (is_load && !mis) ? load_data : ex_out;
            mem_misalign <= mis;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a word-wide SPM model on the bus side.
// Expected values are hand-computed from the memory contents the bench pokes in.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, ex_en, ex_gpr_we_;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_wr_data, ex_out, wr_data, rd_data, mem_out;
    logic [4:0]  ex_dst_addr, mem_dst_addr;
    logic [29:0] addr;
    logic        as_, rw, mem_busy, mem_en, mem_gpr_we_, mem_misalign, state_dbg;

    logic [31:0] spm [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_a = 8'h0;
    logic [31:0] poke_d = 32'h0;
    int          wr_cnt = 0;
    int          pass_cnt = 0;
    int          total = 0;
    int          wc;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ex_en(ex_en),
        .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .addr(addr), .as_(as_),
        .rw(rw), .wr_data(wr_data), .rd_data(rd_data), .mem_busy(mem_busy),
        .mem_en(mem_en), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
        .mem_out(mem_out), .mem_misalign(mem_misalign), .state_dbg(state_dbg)
    );

    assign rd_data = spm[addr[7:0]];

    always @(posedge clk) begin
        if (poke_en) spm[poke_a] <= poke_d;
        else if (!as_ && !rw) begin
            spm[addr[7:0]] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] out,
                         input logic [31:0] wd, input logic [4:0] dst, input logic we_);
        ex_en = en; ex_mem_op = op; ex_out = out; ex_mem_wr_data = wd;
        ex_dst_addr = dst; ex_gpr_we_ = we_;
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic load(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] exp);
        drive(1'b1, op, a, 32'h0, 5'd3, 1'b0);
        chk({tag, "_as"}, 32'(as_), 32'd0);
        chk({tag, "_rw"}, 32'(rw), 32'd1);
        tick();
        chk({tag, "_out"}, mem_out, exp);
        chk({tag, "_en"}, 32'(mem_en), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) spm[i] = 32'h0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1);
        tick(); tick();
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_dst", 32'(mem_dst_addr), 32'd0);
        chk("rst_we", 32'(mem_gpr_we_), 32'd1);
        chk("rst_out", mem_out, 32'h0);
        chk("rst_mis", 32'(mem_misalign), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b0;
        poke(8'h40, 32'h8899AABB);

        load("lb", 4'd4, 32'h101, 32'hFFFFFFAA);
        chk("lb_addr", 32'(addr), 32'h40);
        load("lbu", 4'd5, 32'h101, 32'h000000AA);
        load("lh", 4'd2, 32'h102, 32'hFFFF8899);
        load("lhu", 4'd3, 32'h102, 32'h00008899);
        load("lw", 4'd1, 32'h100, 32'h8899AABB);
        chk("lw_dst", 32'(mem_dst_addr), 32'd3);
        chk("lw_we", 32'(mem_gpr_we_), 32'd0);

        drive(1'b1, 4'd0, 32'hDEADBEEF, 32'h0, 5'd7, 1'b0);
        chk("nop_as", 32'(as_), 32'd1);
        tick();
        chk("nop_out", mem_out, 32'hDEADBEEF);

        drive(1'b1, 4'd6, 32'h200, 32'hCAFEF00D, 5'd1, 1'b0);
        chk("sw_as", 32'(as_), 32'd0);
        chk("sw_rw", 32'(rw), 32'd0);
        chk("sw_wd", wr_data, 32'hCAFEF00D);
        chk("sw_busy", 32'(mem_busy), 32'd0);
        tick();
        chk("sw_mem", spm[8'h80], 32'hCAFEF00D);
        chk("sw_we", 32'(mem_gpr_we_), 32'd1);

        // SB read-modify-write
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1);
        poke(8'h40, 32'h11223344);
        drive(1'b1, 4'd8, 32'h103, 32'h5C, 5'd2, 1'b0);
        chk("sb_rd_as", 32'(as_), 32'd0);
        chk("sb_rd_rw", 32'(rw), 32'd1);
        chk("sb_busy", 32'(mem_busy), 32'd1);
        tick();
        chk("sb_bubble", 32'(mem_en), 32'd0);
        chk("sb_state", 32'(state_dbg), 32'd1);
        chk("sb_wr_as", 32'(as_), 32'd0);
        chk("sb_wr_rw", 32'(rw), 32'd0);
        chk("sb_wr_data", wr_data, 32'h5C223344);
        chk("sb_busy2", 32'(mem_busy), 32'd0);
        tick();
        chk("sb_mem", spm[8'h40], 32'h5C223344);
        chk("sb_en", 32'(mem_en), 32'd1);
        chk("sb_we", 32'(mem_gpr_we_), 32'd1);
        chk("sb_idle", 32'(state_dbg), 32'd0);

        // SH aborted by flush in the write cycle
        drive(1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b1);
        poke(8'h40, 32'h11223344);
        wc = wr_cnt;
        drive(1'b1, 4'd7, 32'h100, 32'hBEEF, 5'd2, 1'b0);
        chk("sh_busy", 32'(mem_busy), 32'd1);
        tick();
        flush = 1'b1; #1;
        chk("shf_as", 32'(as_), 32'd1);
        tick();
        flush = 1'b0;
        chk("shf_mem", spm[8'h40], 32'h11223344);
        chk("shf_wcnt", 32'(wr_cnt), 32'(wc));
        chk("shf_state", 32'(state_dbg), 32'd0);
        chk("shf_en", 32'(mem_en), 32'd0);
        load("shf_next", 4'd1, 32'h100, 32'h11223344);

        // SB with stall held in the write cycle
        wc = wr_cnt;
        drive(1'b1, 4'd8, 32'h100, 32'h77, 5'd4, 1'b0);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sbs_as", 32'(as_), 32'd1);
            tick();
            chk("sbs_state", 32'(state_dbg), 32'd1);
            chk("sbs_hold", 32'(mem_en), 32'd0);
        end
        chk("sbs_wcnt", 32'(wr_cnt), 32'(wc));
        stall = 1'b0; #1;
        chk("sbs_wr_as", 32'(as_), 32'd0);
        chk("sbs_wr_data", wr_data, 32'h11223377);
        tick();
        chk("sbs_wcnt2", 32'(wr_cnt), 32'(wc + 1));
        chk("sbs_mem", spm[8'h40], 32'h11223377);
        chk("sbs_en", 32'(mem_en), 32'd1);

        // misaligned LW
        drive(1'b1, 4'd1, 32'h102, 32'h0, 5'd5, 1'b0);
`ifdef MEM_MISALIGN_EXC_EN
        chk("mis_as", 32'(as_), 32'd1);
        tick();
        chk("mis_flag", 32'(mem_misalign), 32'd1);
        chk("mis_out", mem_out, 32'h102);
        chk("mis_we", 32'(mem_gpr_we_), 32'd1);
`else
        chk("mis_as", 32'(as_), 32'd0);
        chk("mis_addr", 32'(addr), 32'h40);
        tick();
        chk("mis_flag", 32'(mem_misalign), 32'd0);
        chk("mis_out", mem_out, 32'h11223377);
`endif

        // reset mid-RMW
        wc = wr_cnt;
        drive(1'b1, 4'd8, 32'h101, 32'h12, 5'd6, 1'b0);
        tick();
        chk("rrmw_state1", 32'(state_dbg), 32'd1);
        reset = 1'b1; #1;
        chk("rrmw_as", 32'(as_), 32'd1);
        tick();
        chk("rrmw_state", 32'(state_dbg), 32'd0);
        chk("rrmw_wcnt", 32'(wr_cnt), 32'(wc));
        chk("rrmw_mem", spm[8'h40], 32'h11223377);
        chk("rrmw_en", 32'(mem_en), 32'd0);
        reset = 1'b0;
        load("pre_rst_lw", 4'd1, 32'h200, 32'hCAFEF00D);

        // reset on a valid LW
        reset = 1'b1;
        drive(1'b1, 4'd1, 32'h100, 32'h0, 5'd9, 1'b0);
        chk("rlw_as", 32'(as_), 32'd1);
        tick();
        chk("rlw_en", 32'(mem_en), 32'd0);
        chk("rlw_out", mem_out, 32'h0);
        chk("rlw_dst", 32'(mem_dst_addr), 32'd0);
        chk("rlw_we", 32'(mem_gpr_we_), 32'd1);
        reset = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
